// File: rtl/vc_write_buffer.sv
// vc_write_buffer: posted write-back buffer between victim cache and pmem (VCWB_COALESCE_EN merges writes into buffered lines).
// Latency: write / read-hit resp 1 cycle after the request is sampled; read miss = pmem latency + 2.
// Backpressure: writes stall while all DEPTH entries are valid; a pending read miss takes the pmem port before the next drain.
module vc_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {UP_IDLE, UP_RDMISS, UP_RESP} up_state_t;
    typedef enum logic [1:0] {DR_IDLE, DR_WRITE, DR_READ} dr_state_t;

    up_state_t up_state, up_next;
    dr_state_t dr_state, dr_next;

    logic              ent_vld  [DEPTH];
    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [LINE_W-1:0] ent_dat  [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;

    logic             rd_hit, wr_hit;
    logic [PTR_W-1:0] rd_idx, wr_idx, scan_idx;
    logic             up_rd, up_wr, full, push, merge, pop, miss_done;

    assign up_rd     = (up_state == UP_IDLE) && mem_read;
    assign up_wr     = (up_state == UP_IDLE) && mem_write && !mem_read;
    assign full      = (count == CNT_W'(DEPTH));
    assign merge     = up_wr && wr_hit;
    assign push      = up_wr && !wr_hit && !full;
    assign pop       = (dr_state == DR_WRITE) && pmem_resp;
    assign miss_done = (dr_state == DR_READ) && pmem_resp;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        rd_hit   = 1'b0;
        rd_idx   = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PTR_W'(i);
            if (ent_vld[scan_idx] && ent_addr[scan_idx] == mem_address) begin
                rd_hit = 1'b1;
                rd_idx = scan_idx;
            end
        end
    end

`ifdef VCWB_COALESCE_EN
    logic [PTR_W-1:0] wr_scan;

    // The head being written to pmem must not change, so a match there allocates instead.
    always_comb begin
        wr_hit  = 1'b0;
        wr_idx  = '0;
        wr_scan = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_scan = head + PTR_W'(i);
            if (ent_vld[wr_scan] && ent_addr[wr_scan] == mem_address &&
                !(dr_state == DR_WRITE && i == 0)) begin
                wr_hit = 1'b1;
                wr_idx = wr_scan;
            end
        end
    end
`else
    assign wr_hit = 1'b0;
    assign wr_idx = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_state <= UP_IDLE;
            dr_state <= DR_IDLE;
        end else begin
            up_state <= up_next;
            dr_state <= dr_next;
        end
    end

    always_comb begin
        up_next = up_state;
        case (up_state)
            UP_IDLE: begin
                if (up_rd)
                    up_next = rd_hit ? UP_RESP : UP_RDMISS;
                else if (push || merge)
                    up_next = UP_RESP;
            end
            UP_RDMISS: if (miss_done) up_next = UP_RESP;
            UP_RESP:   up_next = UP_IDLE;
            default:   up_next = UP_IDLE;
        endcase
    end

    always_comb begin
        dr_next = dr_state;
        case (dr_state)
            DR_IDLE: begin
                if (up_state == UP_RDMISS)
                    dr_next = DR_READ;
                else if (count != '0)
                    dr_next = DR_WRITE;
            end
            DR_WRITE, DR_READ: if (pmem_resp) dr_next = DR_IDLE;
            default: dr_next = DR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            mem_rdata    <= '0;
            pmem_address <= '0;
            for (int i = 0; i < DEPTH; i++) ent_vld[i] <= 1'b0;
        end else begin
            if (push) begin
                ent_vld[tail] <= 1'b1;
                tail          <= tail + PTR_W'(1);
            end
            if (pop) begin
                ent_vld[head] <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (up_rd && rd_hit)
                mem_rdata <= ent_dat[rd_idx];
            else if (miss_done)
                mem_rdata <= pmem_rdata;
            if (dr_state == DR_IDLE && dr_next == DR_READ)
                pmem_address <= mem_address;
            else if (dr_state == DR_IDLE && dr_next == DR_WRITE)
                pmem_address <= ent_addr[head];
        end
    end

    // Line storage needs no reset: ent_vld gates every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= mem_address;
            ent_dat[tail]  <= mem_wdata;
        end
        if (merge)
            ent_dat[wr_idx] <= mem_wdata;
    end

    // Write data is read live from the head so a merge landing as the drain starts is still sent.
    assign pmem_wdata = pmem_write ? ent_dat[head] : '0;
    assign pmem_read  = (dr_state == DR_READ);
    assign pmem_write = (dr_state == DR_WRITE);
    assign mem_resp   = (up_state == UP_RESP);
    assign empty      = (count == '0) && (dr_state != DR_WRITE);
endmodule

// File: tb/tb_vc_write_buffer.sv
// Bench for vc_write_buffer: model pmem with programmable latency/stall; buffer + pmem must act as one memory.
module tb_vc_write_buffer;
    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_read, mem_write, mem_resp, pmem_read, pmem_write, pmem_resp, empty;
    logic [AW-1:0] mem_address, pmem_address;
    logic [LW-1:0] mem_wdata, mem_rdata, pmem_wdata, pmem_rdata;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int  pmem_lat = 1;
    bit  pmem_stall = 1'b0;
    logic [LW-1:0] pmem_mem [logic [AW-1:0]];
    logic [AW-1:0] wlog_a [$];
    logic [LW-1:0] wlog_d [$];
    bit            ev_wr [$];
    logic [AW-1:0] ev_a [$];
    int            ev_s [$];
    int            ev_e [$];

    vc_write_buffer #(.DEPTH(4), .ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .empty(empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LW-1:0] dflt(input logic [AW-1:0] a);
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // pmem model: answers after pmem_lat cycles unless stalled, logs every completed access.
    logic [AW-1:0] st_a;
    logic [LW-1:0] st_d;
    int            st_c, pm_wait;
    bit            pm_act;
    initial begin
        pmem_resp = 1'b0; pmem_rdata = '0; pm_wait = 0; pm_act = 1'b0;
        st_a = '0; st_d = '0; st_c = 0;
        forever begin
            @(negedge clk);
            if (pmem_resp || !rst_n) begin
                pmem_resp = 1'b0; pm_wait = 0; pm_act = 1'b0;
            end else if (pmem_read || pmem_write) begin
                if (!pm_act) begin
                    pm_act = 1'b1; st_a = pmem_address; st_d = pmem_wdata; st_c = cyc;
                end
                if (!pmem_stall) pm_wait++;
                if (!pmem_stall && pm_wait >= pmem_lat) begin
                    total++;
                    if ((pmem_read && pmem_write) || pmem_address !== st_a ||
                        (pmem_write && pmem_wdata !== st_d)) begin
                        bad++;
                        $display("FAIL pmem_hold: got addr=%0h rd=%0b wr=%0b want addr=%0h one-hot stable",
                                 pmem_address, pmem_read, pmem_write, st_a);
                    end
                    pmem_resp = 1'b1;
                    if (pmem_write) begin
                        pmem_mem[pmem_address] = pmem_wdata;
                        wlog_a.push_back(pmem_address);
                        wlog_d.push_back(pmem_wdata);
                    end else begin
                        pmem_rdata = pmem_mem.exists(pmem_address) ? pmem_mem[pmem_address] : dflt(pmem_address);
                    end
                    ev_wr.push_back(pmem_write); ev_a.push_back(pmem_address);
                    ev_s.push_back(st_c); ev_e.push_back(cyc);
                end
            end
        end
    end

    task automatic do_req(input logic rd, input logic [AW-1:0] a, input logic [LW-1:0] d,
                          output logic [LW-1:0] rdat, output int lat);
        mem_read = rd; mem_write = !rd; mem_address = a; mem_wdata = d;
        lat = -1; rdat = '0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (mem_resp) begin lat = n; rdat = mem_rdata; break; end
        end
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (empty && !pmem_read && !pmem_write && !mem_resp) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0 || empty !== 1'b1) begin
            bad++; $display("FAIL reset_ctl: got resp=%0b prd=%0b pwr=%0b empty=%0b want 0 0 0 1",
                            mem_resp, pmem_read, pmem_write, empty);
        end
        total++;
        if (mem_rdata !== '0 || pmem_address !== '0 || pmem_wdata !== '0) begin
            bad++; $display("FAIL reset_data: got rdata=%0h paddr=%0h want 0", mem_rdata, pmem_address);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (empty !== 1'b1 || pmem_write !== 1'b0) begin
            bad++; $display("FAIL reset_idle: got empty=%0b pwr=%0b want 1 0", empty, pmem_write);
        end
    endtask

    task automatic test_write_drain();
        logic [LW-1:0] d, r;
        int lat, w0, e0;
        bit ok;
        pmem_lat = 3; d = rand_line(); w0 = wlog_a.size(); e0 = ev_s.size();
        do_req(1'b0, 32'h100, d, r, lat);
        total++; if (lat != 1) begin bad++; $display("FAIL wr_lat: got %0d want 1", lat); end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL wr_empty: got %0b want 0", empty); end
        wait_idle(ok);
        total++;
        if (!ok || wlog_a.size() != w0 + 1 || wlog_a[w0] !== 32'h100 || wlog_d[w0] !== d) begin
            bad++; $display("FAIL wr_drain: got %0d writes ok=%0b want one write to 100", wlog_a.size() - w0, ok);
        end
        total++;
        if (ev_s.size() != e0 + 1 || ev_e[e0] - ev_s[e0] != 2) begin
            bad++; $display("FAIL wr_pmem_lat: got %0d events want 1 with 3-cycle hold", ev_s.size() - e0);
        end
    endtask

    task automatic test_read_hit();
        logic [LW-1:0] d, r;
        int lat, e0, nrd;
        bit ok;
        pmem_lat = 4; d = rand_line(); e0 = ev_s.size();
        do_req(1'b0, 32'h100, d, r, lat);
        @(negedge clk);
        do_req(1'b1, 32'h100, '0, r, lat);
        total++; if (lat != 1) begin bad++; $display("FAIL hit_lat: got %0d want 1", lat); end
        total++; if (r !== d) begin bad++; $display("FAIL hit_data: got %0h want %0h", r, d); end
        wait_idle(ok);
        nrd = 0;
        for (int i = e0; i < ev_s.size(); i++) if (!ev_wr[i]) nrd++;
        total++;
        if (!ok || nrd != 0) begin bad++; $display("FAIL hit_no_pmem_read: got %0d reads want 0", nrd); end
    endtask

    task automatic test_full();
        logic [LW-1:0] r;
        int lat, e0, w0, got;
        bit seen, ok;
        pmem_stall = 1'b1; pmem_lat = 1; e0 = ev_s.size(); w0 = wlog_a.size();
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 32'h400 + 32'(i) * 32'h20, rand_line(), r, lat);
            total++; if (lat != 1) begin bad++; $display("FAIL fill_lat%0d: got %0d want 1", i, lat); end
            @(negedge clk);
        end
        mem_write = 1'b1; mem_address = 32'h480; mem_wdata = rand_line();
        seen = 1'b0;
        repeat (10) begin @(negedge clk); if (mem_resp) seen = 1'b1; end
        total++; if (seen) begin bad++; $display("FAIL full_stall: got resp=1 want 0 while full"); end
        pmem_stall = 1'b0;
        got = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (mem_resp) begin got = cyc; break; end
        end
        mem_write = 1'b0;
        total++;
        if (ev_s.size() <= e0 || ev_a[e0] !== 32'h400 || got != ev_e[e0] + 2) begin
            bad++; $display("FAIL full_accept: got resp cycle %0d want pop cycle+2", got);
        end
        wait_idle(ok);
        total++;
        if (!ok || wlog_a.size() != w0 + 5) begin
            bad++; $display("FAIL full_count: got %0d writes want 5", wlog_a.size() - w0);
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (wlog_a[w0 + i] !== 32'h400 + 32'(i) * 32'h20) begin
                    bad++; $display("FAIL full_order%0d: got %0h want %0h", i, wlog_a[w0 + i], 32'h400 + 32'(i) * 32'h20);
                end
            end
        end
    endtask

    task automatic test_miss_priority();
        logic [LW-1:0] r, exp_d;
        int lat, e0;
        bit ok;
        pmem_lat = 5; e0 = ev_s.size();
        do_req(1'b0, 32'h600, rand_line(), r, lat); @(negedge clk);
        do_req(1'b0, 32'h620, rand_line(), r, lat); @(negedge clk);
        exp_d = pmem_mem.exists(32'h200) ? pmem_mem[32'h200] : dflt(32'h200);
        do_req(1'b1, 32'h200, '0, r, lat);
        total++; if (r !== exp_d) begin bad++; $display("FAIL miss_data: got %0h want %0h", r, exp_d); end
        wait_idle(ok);
        total++;
        if (!ok || ev_s.size() != e0 + 3 || !ev_wr[e0] || ev_a[e0] !== 32'h600 || ev_wr[e0+1] ||
            ev_a[e0+1] !== 32'h200 || !ev_wr[e0+2] || ev_a[e0+2] !== 32'h620) begin
            bad++; $display("FAIL miss_order: got %0d events want W600 R200 W620", ev_s.size() - e0);
        end
        total++;
        if (ev_s.size() < e0 + 2 || ev_s[e0+1] <= ev_e[e0]) begin
            bad++; $display("FAIL miss_after_write: got read start %0d want after %0d", ev_s[e0+1], ev_e[e0]);
        end
        pmem_lat = 2;
        exp_d = pmem_mem.exists(32'h220) ? pmem_mem[32'h220] : dflt(32'h220);
        do_req(1'b1, 32'h220, '0, r, lat);
        total++; if (lat != 4) begin bad++; $display("FAIL miss_lat: got %0d want 4", lat); end
        total++; if (r !== exp_d) begin bad++; $display("FAIL miss_data2: got %0h want %0h", r, exp_d); end
    endtask

    task automatic test_dup();
        logic [LW-1:0] x, d1, d2, y, r;
        logic [AW-1:0] exp_a [$];
        logic [LW-1:0] exp_d [$];
        int lat, w0;
        bit ok;
        pmem_stall = 1'b1; pmem_lat = 1; w0 = wlog_a.size();
        x = rand_line(); d1 = rand_line(); d2 = rand_line(); y = rand_line();
        do_req(1'b0, 32'h280, x, r, lat);  @(negedge clk);
        do_req(1'b0, 32'h300, d1, r, lat); @(negedge clk);
        do_req(1'b0, 32'h300, d2, r, lat); @(negedge clk);
        total++; if (lat != 1) begin bad++; $display("FAIL dup_lat: got %0d want 1", lat); end
        do_req(1'b1, 32'h300, '0, r, lat); @(negedge clk);
        total++; if (r !== d2) begin bad++; $display("FAIL dup_youngest: got %0h want %0h", r, d2); end
        do_req(1'b0, 32'h280, y, r, lat);  @(negedge clk);
        do_req(1'b1, 32'h280, '0, r, lat);
        total++; if (r !== y) begin bad++; $display("FAIL dup_head: got %0h want %0h", r, y); end
        pmem_stall = 1'b0;
        wait_idle(ok);
        exp_a.push_back(32'h280); exp_d.push_back(x);
`ifndef VCWB_COALESCE_EN
        exp_a.push_back(32'h300); exp_d.push_back(d1);
`endif
        exp_a.push_back(32'h300); exp_d.push_back(d2);
        exp_a.push_back(32'h280); exp_d.push_back(y);
        total++;
        if (!ok || wlog_a.size() != w0 + exp_a.size()) begin
            bad++; $display("FAIL dup_count: got %0d writes want %0d", wlog_a.size() - w0, exp_a.size());
        end else begin
            for (int i = 0; i < exp_a.size(); i++) begin
                total++;
                if (wlog_a[w0 + i] !== exp_a[i] || wlog_d[w0 + i] !== exp_d[i]) begin
                    bad++; $display("FAIL dup_write%0d: got addr %0h want %0h", i, wlog_a[w0 + i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [LW-1:0] ref_mem [logic [AW-1:0]];
        logic [LW-1:0] d, r, exp_d, got_d;
        logic [AW-1:0] a;
        int lat;
        bit ok;
        ref_mem = pmem_mem;
        for (int k = 0; k < 80; k++) begin
            pmem_lat = $urandom_range(1, 4);
            a = 32'h1000 + 32'($urandom_range(0, 5)) * 32'h20;
            if ($urandom_range(0, 9) < 6) begin
                d = rand_line();
                do_req(1'b0, a, d, r, lat);
                ref_mem[a] = d;
                total++; if (lat < 0) begin bad++; $display("FAIL rnd_wr%0d: got timeout want resp", k); end
            end else begin
                exp_d = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
                do_req(1'b1, a, '0, r, lat);
                total++;
                if (lat < 0 || r !== exp_d) begin
                    bad++; $display("FAIL rnd_rd%0d: got %0h want %0h (addr %0h lat %0d)", k, r, exp_d, a, lat);
                end
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL rnd_drain: got busy want idle"); end
        for (int i = 0; i < 6; i++) begin
            a = 32'h1000 + 32'(i) * 32'h20;
            exp_d = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
            got_d = pmem_mem.exists(a) ? pmem_mem[a] : dflt(a);
            total++;
            if (got_d !== exp_d) begin bad++; $display("FAIL rnd_mem%0d: got %0h want %0h", i, got_d, exp_d); end
        end
    endtask

    task automatic test_reset_mid();
        logic [LW-1:0] r;
        int lat, w0;
        bit seen;
        pmem_stall = 1'b1; w0 = wlog_a.size();
        do_req(1'b0, 32'h500, rand_line(), r, lat);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (pmem_write) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        total++; if (!seen) begin bad++; $display("FAIL rst_setup: got pwr=0 want drain in flight"); end
        rst_n = 1'b0;
        #1;
        total++;
        if (pmem_write !== 1'b0 || pmem_read !== 1'b0 || empty !== 1'b1 || mem_resp !== 1'b0) begin
            bad++; $display("FAIL rst_mid: got pwr=%0b prd=%0b empty=%0b resp=%0b want 0 0 1 0",
                            pmem_write, pmem_read, empty, mem_resp);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        pmem_stall = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (empty !== 1'b1 || pmem_write !== 1'b0 || wlog_a.size() != w0) begin
            bad++; $display("FAIL rst_discard: got empty=%0b writes=%0d want 1 0", empty, wlog_a.size() - w0);
        end
    endtask

    initial begin
        mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0;
        test_reset();
        test_write_drain();
        test_read_hit();
        test_full();
        test_miss_priority();
        test_dup();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
